mem_arbiter: RTL

- Shares the single main-memory port between the instruction-cache refill engine and the data-cache refill/write-back engine.
- Sits between the two cache controllers (which drive ihit/dhit to the pipeline) and the external memory.
- Sequences each grant as a line-sized burst of word beats and returns read data or consumes write data per beat.
- Fixed priority goes to data requests; round-robin is optional.

---
 rtl/mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one main-memory port between the I-cache refill engine
//             and the D-cache refill / write-back engine. Each grant runs a
//             line-sized burst of LINE_WORDS word beats. Read data and write
//             data are passed straight through on every beat.
//
//  Arbitration
//    Default build : fixed priority. D wins over I.
//    MEM_ARB_RR_EN : when both sides request in IDLE, the side that was not
//                    granted last wins. After reset the pointer says
//                    "I last", so D wins the first tie.
//
//  Ports
//    clk, reset                 clock (rising edge), async active-low reset
//    i_req, i_addr              I line read request and miss address
//    i_rvalid, i_rdata, i_beat  I read beat valid, data, beat index
//    i_done                     one-cycle pulse when the I burst completes
//    d_req, d_we, d_addr        D line request (we=1 write-back), address
//    d_wdata, d_wready          D write word for d_beat, beat consumed
//    d_rvalid, d_rdata, d_beat  D read beat valid, data, beat index
//    d_done                     one-cycle pulse when the D burst completes
//    mem_req, mem_we            memory beat request and write enable
//    mem_addr, mem_wdata        beat word address and write data
//    mem_ready, mem_rdata       memory beat accept/return and read data
//
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int BEAT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,

    // I-cache side
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic [BEAT_W-1:0] i_beat,
    output logic              i_done,

    // D-cache side
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_wready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic [BEAT_W-1:0] d_beat,
    output logic              d_done,

    // Memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_IBURST = 2'd1;
    localparam logic [1:0] c_DBURST = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    // Clears the byte offset plus the beat index, giving the line base.
    localparam logic [31:0] c_BASE_MASK = ~((32'd1 << (BEAT_W + 2)) - 32'd1);

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    logic [31:0]       r_base;
    logic [BEAT_W-1:0] r_i_beat;
    logic [BEAT_W-1:0] r_d_beat;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [31:0]       r_mem_addr;
    logic              r_i_done;
    logic              r_d_done;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_hs;
    logic              w_last;
    logic [BEAT_W-1:0] w_beat;
    logic [BEAT_W-1:0] w_beat_next;
    logic [31:0]       w_grant_base;

    // r_mem_req is only ever set inside a burst, so this is a burst handshake.
    assign w_hs        = r_mem_req & mem_ready;
    assign w_beat      = (r_state == c_DBURST) ? r_d_beat : r_i_beat;
    assign w_last      = (w_beat == c_LAST_BEAT);
    assign w_beat_next = w_beat + 1'b1;
    assign w_grant_base = (w_grant_d ? d_addr : i_addr) & c_BASE_MASK;

    // ------------------------------------------------------------------------
    // Grant selection (only meaningful in IDLE)
    // ------------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
    // 1 = D was granted last, 0 = I was granted last.
    logic r_last_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_d <= 1'b0;
        end else if (w_grant_d || w_grant_i) begin
            r_last_d <= w_grant_d;
        end
    end

    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (r_state == c_IDLE) begin
            if (d_req && i_req) begin
                w_grant_d = ~r_last_d;
                w_grant_i =  r_last_d;
            end else begin
                w_grant_d = d_req;
                w_grant_i = i_req;
            end
        end
    end
`else
    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (r_state == c_IDLE) begin
            w_grant_d = d_req;
            w_grant_i = i_req & ~d_req;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant_d) begin
                    w_state_next = c_DBURST;
                end else if (w_grant_i) begin
                    w_state_next = c_IBURST;
                end
            end
            c_IBURST, c_DBURST: begin
                if (w_hs && w_last) begin
                    w_state_next = c_DONE;
                end
            end
            // DONE lasts exactly one cycle; requests are ignored here so the
            // requester has time to drop req after seeing its done pulse.
            c_DONE: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: combinational outputs (per-beat pass-throughs)
    // ------------------------------------------------------------------------
    always_comb begin
        i_rvalid  = 1'b0;
        i_rdata   = 32'd0;
        d_rvalid  = 1'b0;
        d_rdata   = 32'd0;
        d_wready  = 1'b0;
        mem_wdata = 32'd0;
        case (r_state)
            c_IBURST: begin
                i_rvalid = w_hs;
                if (w_hs) begin
                    i_rdata = mem_rdata;
                end
            end
            c_DBURST: begin
                if (r_mem_we) begin
                    // The D-cache drives the word for d_beat; forward it.
                    mem_wdata = d_wdata;
                    d_wready  = w_hs;
                end else begin
                    d_rvalid = w_hs;
                    if (w_hs) begin
                        d_rdata = mem_rdata;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Burst datapath: base/address, beat counters, memory controls, dones
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base     <= 32'd0;
            r_i_beat   <= '0;
            r_d_beat   <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= 32'd0;
            r_i_done   <= 1'b0;
            r_d_done   <= 1'b0;
        end else begin
            // Done pulses are single-cycle by construction.
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_d || w_grant_i) begin
                        r_base     <= w_grant_base;
                        r_mem_addr <= w_grant_base;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= w_grant_d & d_we;
                        r_i_beat   <= '0;
                        r_d_beat   <= '0;
                    end
                end
                c_IBURST, c_DBURST: begin
                    // Without a handshake every registered output holds,
                    // which is how a mem_ready stall is absorbed.
                    if (w_hs) begin
                        if (w_last) begin
                            r_mem_req <= 1'b0;
                            r_mem_we  <= 1'b0;
                            r_i_beat  <= '0;
                            r_d_beat  <= '0;
                            r_i_done  <= (r_state == c_IBURST);
                            r_d_done  <= (r_state == c_DBURST);
                        end else begin
                            r_mem_addr <= r_base +
                                {{(30 - BEAT_W){1'b0}}, w_beat_next, 2'b00};
                            if (r_state == c_IBURST) begin
                                r_i_beat <= w_beat_next;
                            end else begin
                                r_d_beat <= w_beat_next;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registered output drive
    // ------------------------------------------------------------------------
    assign mem_req  = r_mem_req;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign i_beat   = r_i_beat;
    assign d_beat   = r_d_beat;
    assign i_done   = r_i_done;
    assign d_done   = r_d_done;

endmodule
`default_nettype wire
